// File: rtl/muldiv_if.sv
// Handshake/data bundle between EX stage and the multiply/divide unit.
interface muldiv_if #(
    parameter int WIDTH = 32
);
    logic             start;
    logic [1:0]       op;
    logic [WIDTH-1:0] rs_data;
    logic [WIDTH-1:0] rt_data;
    logic             hi_we;
    logic             lo_we;
    logic [WIDTH-1:0] wdata;
    logic [WIDTH-1:0] hi;
    logic [WIDTH-1:0] lo;
    logic             busy;
    logic             done;

    modport master (
        output start, op, rs_data, rt_data, hi_we, lo_we, wdata,
        input  hi, lo, busy, done
    );

    modport slave (
        input  start, op, rs_data, rt_data, hi_we, lo_we, wdata,
        output hi, lo, busy, done
    );
endinterface

// File: rtl/muldiv_unit.sv
// Iterative radix-2 multiply/divide unit holding the architectural HI/LO.
// Operates on magnitudes; sign correction is folded into the final step so
// HI/LO change only on the edge that completes the operation.
module muldiv_unit #(
    parameter int WIDTH = 32
) (
    input  logic     clk,
    input  logic     reset,
    muldiv_if.slave  bus
);
    localparam int CW = $clog2(WIDTH);

    typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

    state_t           state, state_nxt;
    logic [1:0]       op_q;
    logic [WIDTH-1:0] acc_hi, acc_lo, b_mag;
    logic [WIDTH-1:0] hi_q, lo_q;
    logic             sa_q, sb_q, div0_q;
    logic [CW-1:0]    cnt;

    logic             accept, last, s_a, s_b;
    logic [WIDTH-1:0] a_mag_in, b_mag_in;
    logic [WIDTH-1:0] nxt_hi, nxt_lo, res_hi, res_lo;
    logic [WIDTH:0]   sum, rpart, rdiff;
    logic             ge;
    logic [2*WIDTH-1:0] prod;

    assign accept = bus.start && (state != CALC);
    assign last   = (cnt == CW'(WIDTH - 1));

    // Operand sign and magnitude at launch (unsigned ops ignore the MSB)
    always_comb begin
        s_a      = ~bus.op[0] & bus.rs_data[WIDTH-1];
        s_b      = ~bus.op[0] & bus.rt_data[WIDTH-1];
        a_mag_in = s_a ? (WIDTH'(0) - bus.rs_data) : bus.rs_data;
        b_mag_in = s_b ? (WIDTH'(0) - bus.rt_data) : bus.rt_data;
    end

    // State register
    always_ff @(posedge clk) begin
        if (reset) state <= IDLE;
        else       state <= state_nxt;
    end

    // Next-state logic
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (bus.start) state_nxt = CALC;
            CALC:    if (last)      state_nxt = DONE;
            DONE:    state_nxt = bus.start ? CALC : IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // FSM outputs
    always_comb begin
        bus.busy = (state == CALC);
        bus.done = (state == DONE);
    end

    // One iteration: shift-add multiply or restoring-divide step
    always_comb begin
        sum    = {1'b0, acc_hi} + (acc_lo[0] ? {1'b0, b_mag} : '0);
        rpart  = {acc_hi, acc_lo[WIDTH-1]};
        ge     = (rpart >= {1'b0, b_mag});
        rdiff  = ge ? (rpart - {1'b0, b_mag}) : rpart;
        if (op_q[1]) begin
            nxt_hi = rdiff[WIDTH-1:0];
            nxt_lo = {acc_lo[WIDTH-2:0], ge};
        end else begin
            nxt_hi = sum[WIDTH:1];
            nxt_lo = {sum[0], acc_lo[WIDTH-1:1]};
        end
    end

    // Sign correction and divide-by-zero override on the finished step;
    // remainder of a zero divisor is |dividend|, re-signed to the dividend
    always_comb begin
        prod   = {nxt_hi, nxt_lo};
        res_hi = nxt_hi;
        res_lo = nxt_lo;
        if (op_q[1]) begin
            if (sa_q ^ sb_q) res_lo = WIDTH'(0) - nxt_lo;
            if (sa_q)        res_hi = WIDTH'(0) - nxt_hi;
            if (div0_q)      res_lo = '1;
        end else if (sa_q ^ sb_q) begin
            prod   = (2*WIDTH)'(0) - {nxt_hi, nxt_lo};
            res_hi = prod[2*WIDTH-1:WIDTH];
            res_lo = prod[WIDTH-1:0];
        end
    end

    // Datapath, counter and HI/LO update
    always_ff @(posedge clk) begin
        if (reset) begin
            op_q   <= '0;
            acc_hi <= '0;
            acc_lo <= '0;
            b_mag  <= '0;
            sa_q   <= 1'b0;
            sb_q   <= 1'b0;
            div0_q <= 1'b0;
            cnt    <= '0;
            hi_q   <= '0;
            lo_q   <= '0;
        end else begin
            if (accept) begin
                op_q   <= bus.op;
                acc_hi <= '0;
                acc_lo <= a_mag_in;
                b_mag  <= b_mag_in;
                sa_q   <= s_a;
                sb_q   <= s_b;
                div0_q <= (bus.rt_data == '0);
                cnt    <= '0;
            end else if (state == CALC) begin
                acc_hi <= nxt_hi;
                acc_lo <= nxt_lo;
                cnt    <= cnt + 1'b1;
            end
            if (state == CALC) begin
                if (last) begin
                    hi_q <= res_hi;
                    lo_q <= res_lo;
                end
            end else begin
                if (bus.hi_we) hi_q <= bus.wdata;
                if (bus.lo_we) lo_q <= bus.wdata;
            end
        end
    end

    assign bus.hi = hi_q;
    assign bus.lo = lo_q;
endmodule

// File: tb/tb_muldiv_unit.sv
// Self-checking bench for muldiv_unit: directed table, corner sequences,
// and random operations against a plain-arithmetic reference model.
module tb_muldiv_unit;
    logic clk = 1'b0;
    logic reset;
    int   total = 0;
    int   passed = 0;

    muldiv_if #(.WIDTH(32)) bus ();
    muldiv_unit #(.WIDTH(32)) dut (.clk(clk), .reset(reset), .bus(bus));

    always #5 clk = ~clk;

    typedef struct {
        logic [1:0]  op;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] hi;
        logic [31:0] lo;
        string       nm;
    } vec_t;

    vec_t tbl[8];

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act === exp) passed++;
        else $display("FAIL %s: got %h expected %h", nm, act, exp);
    endtask

    // Reference: {hi, lo} from the architectural definition of each op
    function automatic logic [63:0] model(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b);
        longint sa, sb, q, r;
        logic [63:0] ua, ub;
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        ua = {32'b0, a};
        ub = {32'b0, b};
        case (op)
            2'b00: return 64'(sa * sb);
            2'b01: return ua * ub;
            2'b10: begin
                if (b == 0) return {a, 32'hFFFFFFFF};
                q = sa / sb;
                r = sa % sb;
                return {r[31:0], q[31:0]};
            end
            default: begin
                if (b == 0) return {a, 32'hFFFFFFFF};
                return {32'(ua % ub), 32'(ua / ub)};
            end
        endcase
    endfunction

    // Launch one op (from IDLE or DONE) and check latency, busy, hold, result
    task automatic run_op(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b,
                          input logic [63:0] exp, input string nm);
        int n, bc;
        logic [31:0] h0, l0;
        bus.start = 1'b1; bus.op = op; bus.rs_data = a; bus.rt_data = b;
        tick();
        bus.start = 1'b0;
        h0 = bus.hi; l0 = bus.lo;
        n = 0; bc = 0;
        while (!bus.done && n < 40) begin
            if (bus.busy) bc++;
            if (n == 31) check({nm, "_hold"}, {bus.hi, bus.lo}, {h0, l0});
            tick();
            n++;
        end
        check({nm, "_lat"}, 64'(n), 64'd32);
        check({nm, "_busy"}, 64'(bc), 64'd32);
        check({nm, "_hi"}, 64'(bus.hi), 64'(exp[63:32]));
        check({nm, "_lo"}, 64'(bus.lo), 64'(exp[31:0]));
    endtask

    initial begin
        int n, seen;
        logic [1:0]  rop;
        logic [31:0] ra, rb;

        tbl[0] = '{2'b01, 32'hFFFFFFFF, 32'd2,        32'h00000001, 32'hFFFFFFFE, "multu_max"};
        tbl[1] = '{2'b00, 32'hFFFFFFFD, 32'd5,        32'hFFFFFFFF, 32'hFFFFFFF1, "mult_neg"};
        tbl[2] = '{2'b10, 32'hFFFFFFF9, 32'd2,        32'hFFFFFFFF, 32'hFFFFFFFD, "div_neg"};
        tbl[3] = '{2'b11, 32'd100,      32'd0,        32'h00000064, 32'hFFFFFFFF, "divu_zero"};
        tbl[4] = '{2'b10, 32'h80000000, 32'hFFFFFFFF, 32'h00000000, 32'h80000000, "div_ovf"};
        tbl[5] = '{2'b00, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'h00000000, 32'h00000001, "mult_m1m1"};
        tbl[6] = '{2'b10, 32'd7,        32'hFFFFFFFE, 32'h00000001, 32'hFFFFFFFD, "div_posneg"};
        tbl[7] = '{2'b10, 32'hFFFFFFF8, 32'd0,        32'hFFFFFFF8, 32'hFFFFFFFF, "div_zero_neg"};

        bus.start = 0; bus.op = 0; bus.rs_data = 0; bus.rt_data = 0;
        bus.hi_we = 0; bus.lo_we = 0; bus.wdata = 0;
        reset = 1'b1;
        tick();
        reset = 1'b0;
        check("rst_hi", 64'(bus.hi), 64'd0);
        check("rst_lo", 64'(bus.lo), 64'd0);
        check("rst_busy", 64'(bus.busy), 64'd0);
        check("rst_done", 64'(bus.done), 64'd0);

        // Directed table, launched back-to-back from DONE after the first
        for (int i = 0; i < 8; i++)
            run_op(tbl[i].op, tbl[i].a, tbl[i].b, {tbl[i].hi, tbl[i].lo}, tbl[i].nm);
        tick();
        check("idle_after_done", 64'(bus.done), 64'd0);

        // Start and MTHI while busy are ignored
        bus.start = 1; bus.op = 2'b01; bus.rs_data = 6; bus.rt_data = 7;
        tick();
        bus.start = 0;
        n = 0;
        repeat (9) begin tick(); n++; end
        bus.start = 1; bus.op = 2'b11; bus.rs_data = 9; bus.rt_data = 2;
        bus.hi_we = 1; bus.wdata = 32'h1234;
        tick(); n++;
        bus.start = 0; bus.hi_we = 0;
        while (!bus.done && n < 40) begin tick(); n++; end
        check("ign_lat", 64'(n), 64'd32);
        check("ign_hi", 64'(bus.hi), 64'd0);
        check("ign_lo", 64'(bus.lo), 64'd42);
        tick();
        bus.hi_we = 1; bus.wdata = 32'h1234;
        tick();
        bus.hi_we = 0;
        check("mthi_idle", 64'(bus.hi), 64'h1234);
        check("mthi_lo_kept", 64'(bus.lo), 64'd42);

        // MTLO together with start lands at E0, then the result overwrites
        bus.start = 1; bus.op = 2'b01; bus.rs_data = 3; bus.rt_data = 4;
        bus.lo_we = 1; bus.wdata = 32'hABCD;
        tick();
        bus.start = 0; bus.lo_we = 0;
        check("mtlo_e0", 64'(bus.lo), 64'hABCD);
        check("mtlo_e0_busy", 64'(bus.busy), 64'd1);
        n = 0;
        while (!bus.done && n < 40) begin tick(); n++; end
        check("mtlo_res_lo", 64'(bus.lo), 64'd12);
        check("mtlo_res_hi", 64'(bus.hi), 64'd0);

        // Reset in the middle of CALC aborts with no result
        bus.start = 1; bus.op = 2'b01; bus.rs_data = 32'h12345678; bus.rt_data = 32'h9ABC;
        tick();
        bus.start = 0;
        repeat (15) tick();
        reset = 1;
        tick();
        reset = 0;
        check("abort_busy", 64'(bus.busy), 64'd0);
        check("abort_hi", 64'(bus.hi), 64'd0);
        check("abort_lo", 64'(bus.lo), 64'd0);
        seen = 0;
        repeat (40) begin
            if (bus.done) seen++;
            tick();
        end
        check("abort_nodone", 64'(seen), 64'd0);

        // Random ops against the reference model
        for (int i = 0; i < 30; i++) begin
            rop = 2'($urandom_range(0, 3));
            ra = $urandom();
            rb = $urandom();
            case ($urandom_range(0, 5))
                0: rb = 0;
                1: rb = 32'($urandom_range(1, 9));
                2: begin ra = 32'h80000000; rb = 32'hFFFFFFFF; end
                3: ra = 32'($urandom_range(0, 255));
                default: ;
            endcase
            run_op(rop, ra, rb, model(rop, ra, rb), $sformatf("rnd%0d_op%0d", i, rop));
        end

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
